debounce_array: RTL and testbench

Parametrised multi-channel push-button conditioner: synchronises N raw button inputs, debounces each with a shared tick prescaler and a per-channel stability counter, and emits clean level, rise, fall and auto-repeat pulses. It is the single-clock successor to the existing single-button debouncer and feeds the MASTER run/stop and clear controls plus any future front-panel inputs from TOP. No derived or gated clocks are used; the prescaler produces a clock-enable only.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_array_if.sv | 24 ++
 rtl/debounce_channel.sv | 162 ++++++++++++++++
 rtl/debounce_array.sv | 75 +++++++
 tb/tb_debounce_array.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package debounce_pkg;

    // Per-channel debounce state. Level is high in S_HIGH and S_FALL_PEND.
    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_PEND = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_PEND = 2'd3
    } db_state_e;

    // Bits needed to hold values 0..max (at least one bit).
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/debounce_array_if.sv
// Button inputs, conditioned outputs and per-channel debug state.
interface debounce_array_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]      i_btn;
    logic [N_CH-1:0]      o_level;
    logic [N_CH-1:0]      o_rise;
    logic [N_CH-1:0]      o_fall;
    logic [N_CH-1:0]      o_repeat;
    logic                 o_tick;
    logic [N_CH-1:0][1:0] dbg_state;

    // Front-panel side: drives the raw buttons, observes everything else.
    modport master (
        output i_btn,
        input  o_level, o_rise, o_fall, o_repeat, o_tick, dbg_state
    );

    // Debouncer side.
    modport slave (
        input  i_btn,
        output o_level, o_rise, o_fall, o_repeat, o_tick, dbg_state
    );
endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability FSM and auto-repeat counter.
// All decisions are taken only in tick cycles; outputs are registered.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT   = 8,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      tick_i,
    input  logic      btn_i,
    output logic      level_o,
    output logic      rise_o,
    output logic      fall_o,
    output logic      repeat_o,
    output db_state_e state_o
);
    localparam int CW   = cnt_w(STABLE_CNT);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = cnt_w(RMAX);

    logic          sync1_q, sync2_q;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic          rphase_q, rphase_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          rep_q, rep_d;
    logic          s;
    logic          held;

    assign s        = sync2_q;
    assign held     = (state_q == S_HIGH) || (state_q == S_FALL_PEND);
    // Both counters saturate rather than wrap.
    assign cnt_inc  = (cnt_q == CW'(STABLE_CNT)) ? cnt_q : cnt_q + CW'(1);
    assign rcnt_inc = (rcnt_q == RW'(RMAX)) ? rcnt_q : rcnt_q + RW'(1);

    // Two-flop synchroniser; optional inversion sits before the first flop
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i ^ ACTIVE_LOW;
            sync2_q <= sync1_q;
        end
    end

    // State register, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_LOW;
            cnt_q    <= '0;
            rcnt_q   <= '0;
            rphase_q <= 1'b0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            rphase_q <= rphase_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            rep_q    <= rep_d;
        end
    end

    // Next state: count consecutive tick samples that disagree with the level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            unique case (state_q)
                S_LOW: begin
                    if (s) begin
                        if (STABLE_CNT == 1) begin
                            state_d = S_HIGH;
                        end else begin
                            state_d = S_RISE_PEND;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                S_RISE_PEND: begin
                    if (!s) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_inc == CW'(STABLE_CNT)) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        if (STABLE_CNT == 1) begin
                            state_d = S_LOW;
                        end else begin
                            state_d = S_FALL_PEND;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                S_FALL_PEND: begin
                    if (s) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_inc == CW'(STABLE_CNT)) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs: edge pulses from state transitions, repeat from the held-tick counter
    always_comb begin
        level_d  = (state_d == S_HIGH) || (state_d == S_FALL_PEND);
        rise_d   = tick_i && !held && (state_d == S_HIGH);
        fall_d   = tick_i && held && (state_d == S_LOW);
        rep_d    = 1'b0;
        rcnt_d   = rcnt_q;
        rphase_d = rphase_q;
        if (rise_d) begin
            rcnt_d   = '0;
            rphase_d = 1'b0;
        end else if (tick_i && held && !fall_d && (REPEAT_DELAY != 0)) begin
            // First pulse after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
            if (rcnt_inc == (rphase_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
                rep_d    = 1'b1;
                rcnt_d   = '0;
                rphase_d = 1'b1;
            end else begin
                rcnt_d = rcnt_inc;
            end
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign repeat_o = rep_q;
    assign state_o  = state_q;

endmodule

// File: rtl/debounce_array.sv
// N-channel push-button conditioner: one shared tick prescaler (a clock
// enable, not a clock) feeding N independent debounce channels.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 100,
    parameter int STABLE_CNT   = 8,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    debounce_array_if.slave  bus
);
    localparam int PW = cnt_w(TICK_DIV - 1);

    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic [N_CH-1:0]      level_w, rise_w, fall_w, rep_w;
    db_state_e            state_w [N_CH];
    logic [N_CH-1:0][1:0] dbg_w;

    // Prescaler next value; tick is registered so it is high while the count is TICK_DIV-1
    always_comb begin
        presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == PW'(TICK_DIV - 1));
    end

    // Prescaler registers
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT   (STABLE_CNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick_i   (tick_q),
            .btn_i    (bus.i_btn[g]),
            .level_o  (level_w[g]),
            .rise_o   (rise_w[g]),
            .fall_o   (fall_w[g]),
            .repeat_o (rep_w[g]),
            .state_o  (state_w[g])
        );
    end

    // Collect per-channel FSM states for observation
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            dbg_w[i] = state_w[i];
        end
    end

    assign bus.o_level   = level_w;
    assign bus.o_rise    = rise_w;
    assign bus.o_fall    = fall_w;
    assign bus.o_repeat  = rep_w;
    assign bus.o_tick    = tick_q;
    assign bus.dbg_state = dbg_w;

endmodule

// File: tb/tb_debounce_array.sv
`timescale 1ns/1ps
module tb_debounce_array;
    import debounce_pkg::*;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    debounce_array_if #(.N_CH(N)) bus ();
    debounce_array_if #(.N_CH(N)) bus_al ();

    debounce_array #(.N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC), .REPEAT_DELAY(RD),
                     .REPEAT_RATE(RR), .ACTIVE_LOW(1'b0))
        dut (.clk(clk), .reset(reset), .bus(bus));

    debounce_array #(.N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC), .REPEAT_DELAY(RD),
                     .REPEAT_RATE(RR), .ACTIVE_LOW(1'b1))
        dut_al (.clk(clk), .reset(reset), .bus(bus_al));

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Works from the rules: a new level is accepted after SC consecutive tick
    // samples that disagree with it; repeats fire when the number of held ticks
    // since the rise equals RD, RD+RR, RD+2*RR, ...
    int              m_presc;
    logic [N-1:0]    m_s1, m_s2, m_level, m_rise, m_fall, m_rep;
    logic            m_tick;
    int              m_run  [N];
    int              m_held [N];
    bit              m_valid = 1'b0;
    bit              m_was, m_fell;

    always @(posedge clk) begin
        if (reset) begin
            m_presc = 0;
            m_s1 = '0; m_s2 = '0; m_level = '0;
            m_rise = '0; m_fall = '0; m_rep = '0; m_tick = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_run[c]  = 0;
                m_held[c] = 0;
            end
            m_valid = 1'b1;
        end else begin
            m_rise = '0; m_fall = '0; m_rep = '0;
            if (m_presc == TD - 1) begin
                for (int c = 0; c < N; c++) begin
                    m_was  = m_level[c];
                    m_fell = 1'b0;
                    if (m_s2[c] != m_level[c]) begin
                        m_run[c]++;
                        if (m_run[c] == SC) begin
                            m_level[c] = ~m_level[c];
                            m_run[c]   = 0;
                            m_held[c]  = 0;
                            if (m_level[c]) m_rise[c] = 1'b1;
                            else begin
                                m_fall[c] = 1'b1;
                                m_fell    = 1'b1;
                            end
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                    if (m_was && !m_fell) begin
                        m_held[c]++;
                        if (RD != 0 && m_held[c] >= RD && ((m_held[c] - RD) % RR) == 0)
                            m_rep[c] = 1'b1;
                    end
                end
            end
            m_presc = (m_presc == TD - 1) ? 0 : m_presc + 1;
            m_s2    = m_s1;
            m_s1    = bus.i_btn;
            m_tick  = (m_presc == TD - 1);
        end
    end

    // Scoreboard: compare every cycle away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model level",  bus.o_level,  m_level);
            check("model rise",   bus.o_rise,   m_rise);
            check("model fall",   bus.o_fall,   m_fall);
            check("model repeat", bus.o_repeat, m_rep);
            check("model tick",   bus.o_tick,   m_tick);
        end
    end

    // Active-low instance: must stay silent while its buttons are held high
    int al_bad = 0;
    always @(negedge clk) begin
        if (m_valid && bus_al.i_btn == '1)
            al_bad += int'(|(bus_al.o_level | bus_al.o_rise | bus_al.o_fall | bus_al.o_repeat));
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] mask;
        int           hold;
        int           exp_rise;
        int           exp_fall;
        int           exp_rep;
        bit           exp_all_rise;
    } vec_t;

    vec_t tbl [6];
    int   rc [N];
    int   fc [N];
    int   pc [N];
    bit   saw_all;
    int   lat, cnt_a, cnt_b, t_rise, n_fall, rep_after;
    int   rep_k [$];
    int   hold_left [N];

    task automatic align_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_tick !== 1'b1 && n < 2 * TD);
        check("align tick", bus.o_tick, 1'b1);
    endtask

    task automatic release_all();
        bus.i_btn = '0;
        repeat (30) @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver ----------------
    initial begin
        // Press is applied in a tick cycle; release after 'hold' clocks (a tick multiple).
        tbl[0] = '{4'b0001,  8, 0, 0, 0, 1'b0};
        tbl[1] = '{4'b0010, 12, 1, 1, 0, 1'b0};
        tbl[2] = '{4'b0100, 24, 1, 1, 1, 1'b0};
        tbl[3] = '{4'b1111, 40, 1, 1, 3, 1'b1};
        tbl[4] = '{4'b1000, 32, 1, 1, 2, 1'b0};
        tbl[5] = '{4'b0101,  4, 0, 0, 0, 1'b0};

        reset        = 1'b1;
        bus.i_btn    = '0;
        bus_al.i_btn = '1;
        repeat (3) @(negedge clk);
        check("reset level",  bus.o_level,  '0);
        check("reset rise",   bus.o_rise,   '0);
        check("reset fall",   bus.o_fall,   '0);
        check("reset repeat", bus.o_repeat, '0);
        check("reset tick",   bus.o_tick,   1'b0);
        check("reset state",  bus.dbg_state, '0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven presses
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < N; c++) begin
                rc[c] = 0; fc[c] = 0; pc[c] = 0;
            end
            saw_all = 1'b0;
            align_tick();
            bus.i_btn = tbl[i].mask;
            for (int k = 1; k <= tbl[i].hold + 24; k++) begin
                @(negedge clk);
                for (int c = 0; c < N; c++) begin
                    rc[c] += int'(bus.o_rise[c]);
                    fc[c] += int'(bus.o_fall[c]);
                    pc[c] += int'(bus.o_repeat[c]);
                end
                if (bus.o_rise == 4'b1111) saw_all = 1'b1;
                if (k == tbl[i].hold) bus.i_btn = '0;
            end
            for (int c = 0; c < N; c++) begin
                check($sformatf("tbl%0d rise ch%0d", i, c), rc[c], tbl[i].mask[c] ? tbl[i].exp_rise : 0);
                check($sformatf("tbl%0d fall ch%0d", i, c), fc[c], tbl[i].mask[c] ? tbl[i].exp_fall : 0);
                check($sformatf("tbl%0d rep ch%0d", i, c),  pc[c], tbl[i].mask[c] ? tbl[i].exp_rep : 0);
            end
            check($sformatf("tbl%0d all rise", i), saw_all, tbl[i].exp_all_rise);
            repeat (4) @(negedge clk);
        end

        // Clean press on ch0 at a random prescaler phase, held 100 clocks
        repeat ($urandom_range(0, 7)) @(negedge clk);
        bus.i_btn = 4'b0001;
        lat = -1; cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (lat < 0 && bus.o_level[0]) lat = k;
            cnt_a += int'(bus.o_rise[0]);
            cnt_b += int'(|(bus.o_rise[3:1] | bus.o_fall[3:1] | bus.o_repeat[3:1] | bus.o_level[3:1]));
        end
        check_range("clean latency", lat, 11, 15);
        check("clean rise count", cnt_a, 1);
        check("clean other ch", cnt_b, 0);
        release_all();

        // Bounce on ch1: toggles every 5 clocks for 40 clocks, then holds high
        bus.i_btn = 4'b0010;
        cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cnt_a += int'(bus.o_rise[1]);
            if (k % 5 == 0) bus.i_btn[1] = (k == 40) ? 1'b1 : ~bus.i_btn[1];
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            cnt_b += int'(bus.o_rise[1]);
        end
        check("bounce early rise", cnt_a, 0);
        check("bounce final rise", cnt_b, 1);
        release_all();

        // Auto-repeat on ch2
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.i_btn = 4'b0100;
        t_rise = -1;
        for (int k = 1; k <= 20 && t_rise < 0; k++) begin
            @(negedge clk);
            if (bus.o_rise[2]) t_rise = k;
        end
        check("repeat saw rise", t_rise > 0, 1'b1);
        rep_k.delete();
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.o_repeat[2]) rep_k.push_back(k);
        end
        check("repeat count", rep_k.size(), 8);
        if (rep_k.size() > 0) check("repeat first delay", rep_k[0], 20);
        for (int i = 1; i < rep_k.size(); i++)
            check($sformatf("repeat period %0d", i), rep_k[i] - rep_k[i-1], 8);
        bus.i_btn = '0;
        n_fall = 0; rep_after = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (n_fall > 0 && bus.o_repeat[2]) rep_after++;
            n_fall += int'(bus.o_fall[2]);
        end
        check("repeat fall count", n_fall, 1);
        check("repeat after fall", rep_after, 0);
        repeat (5) @(negedge clk);

        // Reset 6 clocks into a press on ch3
        bus.i_btn = 4'b1000;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst outputs", {bus.o_level, bus.o_rise, bus.o_fall, bus.o_repeat, bus.o_tick}, '0);
        check("midrst al outputs", {bus_al.o_level, bus_al.o_rise, bus_al.o_fall, bus_al.o_repeat}, '0);
        reset = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (lat < 0 && bus.o_rise[3]) lat = k;
        end
        check_range("midrst fresh rise", lat, 11, 15);
        release_all();

        // Randomised activity checked by the model every cycle
        for (int c = 0; c < N; c++) hold_left[c] = $urandom_range(1, 40);
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < N; c++) begin
                hold_left[c]--;
                if (hold_left[c] <= 0) begin
                    bus.i_btn[c] = ~bus.i_btn[c];
                    hold_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                                : $urandom_range(8, 60);
                end
            end
            if ($urandom_range(0, 599) == 0) reset = 1'b1;
        end
        reset = 1'b0;
        release_all();

        // Active-low instance: silent while held high, rises when driven low
        check("al idle pulses", al_bad, 0);
        check("al idle level", bus_al.o_level, '0);
        bus_al.i_btn = 4'b1110;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lat < 0 && bus_al.o_rise[0]) lat = k;
        end
        check_range("al rise latency", lat, 11, 15);
        check("al level", bus_al.o_level, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
